// File: rtl/agc_pkg.sv
// Shared types and helpers for the ADC auto-gain controller: FSM/verdict enums,
// default 12-bit 4-level threshold tables, table slicing and window classification.
package agc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_EVAL   = 2'd2,
    ST_SETTLE = 2'd3
  } agc_state_e;

  typedef enum logic [1:0] {
    VD_OK   = 2'd0,
    VD_UP   = 2'd1,
    VD_DOWN = 2'd2
  } agc_verdict_e;

  localparam int AGC_DEF_ADC_W     = 12;
  localparam int AGC_DEF_NUM_GAINS = 4;

  // Entry i lives at [i*ADC_W +: ADC_W]; the rightmost literal is gain index 0.
  localparam logic [AGC_DEF_NUM_GAINS*AGC_DEF_ADC_W-1:0] AGC_DEF_LOWER_TBL =
    {12'd1798, 12'd1791, 12'd1791, 12'd1791};
  localparam logic [AGC_DEF_NUM_GAINS*AGC_DEF_ADC_W-1:0] AGC_DEF_UPPER_TBL =
    {12'd3883, 12'd3723, 12'd3883, 12'd3685};

  localparam int TBL_MAX_BITS = 512;

  function automatic logic [31:0] tbl_slice(input logic [TBL_MAX_BITS-1:0] tbl,
                                            input int unsigned idx,
                                            input int unsigned w);
    logic [TBL_MAX_BITS-1:0] sh;
    sh = tbl >> (idx * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

  // Too-hot beats too-quiet when both limits are crossed.
  function automatic agc_verdict_e classify(input logic [31:0] peak,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
    if (peak > hi) return VD_DOWN;
    if (peak < lo) return VD_UP;
    return VD_OK;
  endfunction

endpackage

// File: rtl/agc_window_stats.sv
// Per-window peak/valley/count accumulator; done fires with the final sample of
// a 2**WIN_LOG2 window so the updated extremes are visible on the next clock.
module agc_window_stats #(
  parameter int ADC_W    = 12,
  parameter int WIN_LOG2 = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             smp_vld,
  input  logic [ADC_W-1:0] smp,
  output logic [ADC_W-1:0] peak,
  output logic [ADC_W-1:0] valley,
  output logic             done
);

  localparam logic [WIN_LOG2:0] LAST = {1'b0, {WIN_LOG2{1'b1}}};

  logic [ADC_W-1:0]  peak_q, peak_d, valley_q, valley_d;
  logic [WIN_LOG2:0] cnt_q, cnt_d;
  logic              take;

  always_comb begin
    peak_d   = peak_q;
    valley_d = valley_q;
    cnt_d    = cnt_q;
    take     = smp_vld && !clr && !cnt_q[WIN_LOG2];
    if (clr) begin
      peak_d   = '0;
      valley_d = '1;
      cnt_d    = '0;
    end else if (take) begin
      if (smp > peak_q)   peak_d   = smp;
      if (smp < valley_q) valley_d = smp;
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign done   = take && (cnt_q == LAST);
  assign peak   = peak_q;
  assign valley = valley_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q   <= '0;
      valley_q <= '1;
      cnt_q    <= '0;
    end else begin
      peak_q   <= peak_d;
      valley_q <= valley_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/agc_gain_ctrl_param.sv
// ADC front-end auto-gain controller: window verdicts with multi-window confirmation,
// over-voltage fast step-down, hold, post-step settle and loss-of-signal watchdog.
module agc_gain_ctrl_param
  import agc_pkg::*;
#(
  parameter int ADC_W       = 12,
  parameter int NUM_GAINS   = 4,
  parameter int GIDX_W      = $clog2(NUM_GAINS),
  parameter int WIN_LOG2    = 9,
  parameter int CONFIRM_WIN = 2,
  parameter int SETTLE_CYC  = 1000,
  parameter int WDOG_CYC    = 6_600_000,
  parameter int OV_THRESH   = 3941,
  parameter logic [NUM_GAINS*ADC_W-1:0] LOWER_TBL = AGC_DEF_LOWER_TBL,
  parameter logic [NUM_GAINS*ADC_W-1:0] UPPER_TBL = AGC_DEF_UPPER_TBL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adc_valid,
  input  logic [ADC_W-1:0]  adc_data,
  input  logic              hold,
  output logic [GIDX_W-1:0] gain_idx,
  output logic [GIDX_W-1:0] relay_ctrl,
  output logic              stable,
  output logic              gain_changed,
  output logic              sig_lost,
  output logic [ADC_W-1:0]  win_peak,
  output logic [ADC_W-1:0]  win_valley
);

  localparam int WD_W = $clog2(WDOG_CYC + 1);
  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CF_W = $clog2(CONFIRM_WIN + 1);

  localparam logic [ADC_W-1:0]  OV_LVL  = ADC_W'(OV_THRESH);
  localparam logic [GIDX_W-1:0] G_MAX   = GIDX_W'(NUM_GAINS - 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WDOG_CYC - 1);
  localparam logic [WD_W-1:0]   WD_SAT  = WD_W'(WDOG_CYC);
  localparam logic [ST_W-1:0]   ST_LAST = ST_W'(SETTLE_CYC - 1);
  localparam logic [CF_W-1:0]   CF_TGT  = CF_W'(CONFIRM_WIN);

  agc_state_e        state_q, state_d;
  agc_verdict_e      lastvd_q, lastvd_d, vd;
  logic [GIDX_W-1:0] g_q, g_d, relay_q, relay_d;
  logic              stable_q, stable_d, gchg_q, gchg_d, lost_q, lost_d;
  logic [ADC_W-1:0]  wpk_q, wpk_d, wvl_q, wvl_d;
  logic [CF_W-1:0]   conf_q, conf_d, conf_nxt;
  logic [ST_W-1:0]   settle_q, settle_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic              wdog_fire, lost_clr, ov_step, stats_clr, stats_vld, stats_done;
  logic              at_bound, eval_step;
  logic [ADC_W-1:0]  st_peak, st_valley, lower_g, upper_g;

  agc_window_stats #(
    .ADC_W    (ADC_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_stats (
    .clk     (clk),
    .rst     (rst),
    .clr     (stats_clr),
    .smp_vld (stats_vld),
    .smp     (adc_data),
    .peak    (st_peak),
    .valley  (st_valley),
    .done    (stats_done)
  );

  // Event decode shared by the next-state and datapath processes.
  always_comb begin
    wdog_fire = !adc_valid && (wdog_q == WD_LAST);
    lost_clr  = lost_q && adc_valid;
    ov_step   = (state_q == ST_SAMPLE) && adc_valid && !lost_q &&
                (adc_data >= OV_LVL) && (g_q != '0);
    stats_clr = (state_q == ST_IDLE);
    stats_vld = (state_q == ST_SAMPLE) && adc_valid && !lost_q && !ov_step;

    lower_g = ADC_W'(tbl_slice(TBL_MAX_BITS'(LOWER_TBL), 32'(g_q), 32'(ADC_W)));
    upper_g = ADC_W'(tbl_slice(TBL_MAX_BITS'(UPPER_TBL), 32'(g_q), 32'(ADC_W)));
    vd      = classify(32'(st_peak), 32'(lower_g), 32'(upper_g));

    at_bound  = ((vd == VD_UP) && (g_q == G_MAX)) || ((vd == VD_DOWN) && (g_q == '0));
    conf_nxt  = ((vd == lastvd_q) && (conf_q != '0)) ? conf_q + 1'b1 : CF_W'(1);
    eval_step = (vd != VD_OK) && !at_bound && !hold && (conf_nxt == CF_TGT);

    wdog_d = wdog_q;
    if (adc_valid)             wdog_d = '0;
    else if (wdog_q != WD_SAT) wdog_d = wdog_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (wdog_fire || lost_clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_SAMPLE;
        ST_SAMPLE: begin
          if (ov_step)         state_d = ST_SETTLE;
          else if (stats_done) state_d = ST_EVAL;
        end
        ST_EVAL:   state_d = eval_step ? ST_SETTLE : ST_IDLE;
        ST_SETTLE: if (settle_q == ST_LAST) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    g_d      = g_q;
    stable_d = stable_q;
    gchg_d   = 1'b0;
    lost_d   = lost_q;
    wpk_d    = wpk_q;
    wvl_d    = wvl_q;
    conf_d   = conf_q;
    lastvd_d = lastvd_q;
    settle_d = settle_q;
    if (wdog_fire) begin
      lost_d   = 1'b1;
      g_d      = '0;
      gchg_d   = (g_q != '0);
      stable_d = 1'b0;
      conf_d   = '0;
    end else if (lost_clr) begin
      lost_d = 1'b0;
    end else begin
      case (state_q)
        ST_SAMPLE: begin
          if (ov_step) begin
            g_d      = g_q - 1'b1;
            gchg_d   = 1'b1;
            stable_d = 1'b0;
            conf_d   = '0;
            settle_d = '0;
          end
        end
        ST_EVAL: begin
          wpk_d    = st_peak;
          wvl_d    = st_valley;
          lastvd_d = vd;
          stable_d = (vd == VD_OK);
          if ((vd == VD_OK) || at_bound || hold) begin
            conf_d = '0;
          end else if (eval_step) begin
            g_d      = (vd == VD_UP) ? g_q + 1'b1 : g_q - 1'b1;
            gchg_d   = 1'b1;
            conf_d   = '0;
            settle_d = '0;
          end else begin
            conf_d = conf_nxt;
          end
        end
        ST_SETTLE: settle_d = settle_q + 1'b1;
        default: ;
      endcase
    end
    relay_d = g_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_q      <= '0;
      relay_q  <= '0;
      stable_q <= 1'b0;
      gchg_q   <= 1'b0;
      lost_q   <= 1'b0;
      wpk_q    <= '0;
      wvl_q    <= '1;
      conf_q   <= '0;
      lastvd_q <= VD_OK;
      settle_q <= '0;
      wdog_q   <= '0;
    end else begin
      g_q      <= g_d;
      relay_q  <= relay_d;
      stable_q <= stable_d;
      gchg_q   <= gchg_d;
      lost_q   <= lost_d;
      wpk_q    <= wpk_d;
      wvl_q    <= wvl_d;
      conf_q   <= conf_d;
      lastvd_q <= lastvd_d;
      settle_q <= settle_d;
      wdog_q   <= wdog_d;
    end
  end

  assign gain_idx     = g_q;
  assign relay_ctrl   = relay_q;
  assign stable       = stable_q;
  assign gain_changed = gchg_q;
  assign sig_lost     = lost_q;
  assign win_peak     = wpk_q;
  assign win_valley   = wvl_q;

endmodule

// File: tb/tb_agc_gain_ctrl_param.sv
// Randomised + directed bench for agc_gain_ctrl_param against a window-queue
// reference model evaluated once per clock.
module tb_agc_gain_ctrl_param;

  localparam int ADC_W  = 12;
  localparam int NG     = 4;
  localparam int WIN    = 16;
  localparam int SETTLE = 8;
  localparam int WDOG   = 100;
  localparam int CONF   = 2;
  localparam int OV     = 3941;
  localparam int LOWER [NG] = '{1791, 1791, 1791, 1798};
  localparam int UPPER [NG] = '{3685, 3883, 3723, 3883};

  localparam int P_WAIT = 0, P_COLLECT = 1, P_JUDGE = 2, P_QUIET = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             adc_valid;
  logic [ADC_W-1:0] adc_data;
  logic             hold;
  logic [1:0]       gain_idx, relay_ctrl;
  logic             stable, gain_changed, sig_lost;
  logic [ADC_W-1:0] win_peak, win_valley;

  agc_gain_ctrl_param #(
    .ADC_W(ADC_W), .NUM_GAINS(NG), .WIN_LOG2(4), .CONFIRM_WIN(CONF),
    .SETTLE_CYC(SETTLE), .WDOG_CYC(WDOG), .OV_THRESH(OV)
  ) dut (
    .clk(clk), .rst(rst), .adc_valid(adc_valid), .adc_data(adc_data), .hold(hold),
    .gain_idx(gain_idx), .relay_ctrl(relay_ctrl), .stable(stable),
    .gain_changed(gain_changed), .sig_lost(sig_lost),
    .win_peak(win_peak), .win_valley(win_valley)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_gc = 0;

  // reference model state
  int m_g, m_stable, m_gc, m_lost, m_peak, m_valley, m_conf, m_last;
  int m_settle, m_quiet, m_phase;
  int win_q[$];

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_g = 0; m_stable = 0; m_gc = 0; m_lost = 0; m_peak = 0; m_valley = 4095;
    m_conf = 0; m_last = -1; m_settle = 0; m_quiet = 0; m_phase = P_WAIT;
    win_q.delete();
  endfunction

  function automatic void model_step(input bit v, input int d, input bit h);
    int pk, vl, vd;
    m_gc = 0;
    if (v) m_quiet = 0;
    else if (m_quiet < WDOG) begin
      m_quiet++;
      if (m_quiet == WDOG) begin
        if (m_g > 0) m_gc = 1;
        m_g = 0; m_lost = 1; m_stable = 0; m_conf = 0; m_phase = P_WAIT;
        return;
      end
    end
    if (m_lost && v) begin
      m_lost = 0; m_phase = P_WAIT;
      return;
    end
    case (m_phase)
      P_WAIT: begin win_q.delete(); m_phase = P_COLLECT; end
      P_COLLECT: if (v) begin
        if (d >= OV && m_g > 0) begin
          m_g--; m_gc = 1; m_stable = 0; m_conf = 0; m_settle = SETTLE; m_phase = P_QUIET;
        end else begin
          win_q.push_back(d);
          if (win_q.size() == WIN) m_phase = P_JUDGE;
        end
      end
      P_JUDGE: begin
        pk = 0; vl = 4095;
        foreach (win_q[i]) begin
          if (win_q[i] > pk) pk = win_q[i];
          if (win_q[i] < vl) vl = win_q[i];
        end
        m_peak = pk; m_valley = vl;
        vd = (pk > UPPER[m_g]) ? 2 : (pk < LOWER[m_g]) ? 1 : 0;
        m_phase = P_WAIT;
        if (vd == 0) begin
          m_stable = 1; m_conf = 0;
        end else begin
          m_stable = 0;
          if ((vd == 1 && m_g == NG-1) || (vd == 2 && m_g == 0) || h) m_conf = 0;
          else begin
            m_conf = (vd == m_last && m_conf > 0) ? m_conf + 1 : 1;
            if (m_conf == CONF) begin
              m_g += (vd == 1) ? 1 : -1;
              m_gc = 1; m_conf = 0; m_settle = SETTLE; m_phase = P_QUIET;
            end
          end
        end
        m_last = vd;
      end
      default: begin
        m_settle--;
        if (m_settle == 0) m_phase = P_WAIT;
      end
    endcase
  endfunction

  task automatic compare_all();
    chk("gain_idx",     int'(gain_idx),     m_g);
    chk("relay_ctrl",   int'(relay_ctrl),   m_g);
    chk("gain_changed", int'(gain_changed), m_gc);
    chk("sig_lost",     int'(sig_lost),     m_lost);
    chk("stable",       int'(stable),       m_stable);
    chk("win_peak",     int'(win_peak),     m_peak);
    chk("win_valley",   int'(win_valley),   m_valley);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(adc_valid, int'(adc_data), hold);
    @(negedge clk);
    if (gain_changed) n_gc++;
    compare_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic smp(input int d);
    adc_valid = 1'b1; adc_data = 12'(d);
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic window(input int lo, input int hi);
    for (int i = 0; i < WIN; i++) begin
      idle($urandom_range(2, 0));
      smp($urandom_range(hi, lo));
    end
    idle(3);
  endtask

  task automatic apply_reset();
    rst = 1'b1; adc_valid = 1'b0; hold = 1'b0;
    model_reset();
    #1;
    compare_all();
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; adc_valid = 1'b0; adc_data = '0; hold = 1'b0;
    @(negedge clk);
    apply_reset();
    chk("rst_gain", int'(gain_idx), 0);
    chk("rst_valley", int'(win_valley), 4095);
    idle(2);

    // 1: in-range window at lowest gain
    window(2500, 2500);
    chk("t1_stable", int'(stable), 1);
    chk("t1_peak", int'(win_peak), 2500);
    chk("t1_valley", int'(win_valley), 2500);

    // 2: two quiet windows step the gain up once
    n_gc = 0;
    window(1000, 1000);
    chk("t2_no_step_yet", int'(gain_idx), 0);
    window(1000, 1000);
    chk("t2_gain", int'(gain_idx), 1);
    chk("t2_relay", int'(relay_ctrl), 1);
    chk("t2_pulses", n_gc, 1);
    idle(10);

    // 3: over-voltage at g=2 steps down immediately
    window(1000, 1000); window(1000, 1000); idle(10);
    chk("t3_g2", int'(gain_idx), 2);
    smp(3950);
    chk("t3_ov_gain", int'(gain_idx), 1);
    chk("t3_ov_pulse", int'(gain_changed), 1);
    chk("t3_ov_stable", int'(stable), 0);
    idle(12);

    // 4: alternating verdicts never confirm
    window(1000, 1000); window(3900, 3900); window(1000, 1000);
    chk("t4_no_step", int'(gain_idx), 1);

    // 5: hold freezes window steps but not over-voltage
    hold = 1'b1;
    window(1000, 1000); window(1000, 1000); window(1000, 1000);
    chk("t5_hold_gain", int'(gain_idx), 1);
    chk("t5_hold_stable", int'(stable), 0);
    smp(4000);
    chk("t5_ov_gain", int'(gain_idx), 0);
    hold = 1'b0;
    idle(12);

    // 6: climb to g=3, starve the watchdog, recover, reset mid-settle
    for (int k = 0; k < 3; k++) begin
      window(1000, 1000); window(1000, 1000); idle(10);
    end
    chk("t6_g3", int'(gain_idx), 3);
    n_gc = 0;
    idle(105);
    chk("t6_lost", int'(sig_lost), 1);
    chk("t6_gain0", int'(gain_idx), 0);
    chk("t6_pulse", n_gc, 1);
    smp(2000);
    chk("t6_lost_clr", int'(sig_lost), 0);
    idle(2);
    window(1000, 1000); window(1000, 1000);
    chk("t6_in_settle", m_phase, P_QUIET);
    apply_reset();
    chk("t6_rst_gain", int'(gain_idx), 0);
    chk("t6_rst_peak", int'(win_peak), 0);
    idle(2);

    // randomised traffic
    for (int s = 0; s < 60; s++) begin
      int kind;
      kind = $urandom_range(6, 0);
      case (kind)
        0: window(1900, 3600);
        1: window(200, 1780);
        2: window(3890, 3940);
        3: begin smp($urandom_range(4095, OV)); idle($urandom_range(12, 0)); end
        4: idle($urandom_range(130, 90));
        5: hold = ($urandom_range(3, 0) == 0);
        default: window(0, 4095);
      endcase
    end
    hold = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
